// File: rtl/fp_pkg.sv
// Shared fixed-point definitions for the skin-tone datapath multipliers:
// default word format, clamp constants, lane packing and rounding helpers.
package fp_pkg;

  localparam int FP_WIDTH_DEF = 16;
  localparam int FP_FRAC_DEF  = 8;

  localparam logic signed [FP_WIDTH_DEF-1:0] FP_MAX = {1'b0, {(FP_WIDTH_DEF-1){1'b1}}};
  localparam logic signed [FP_WIDTH_DEF-1:0] FP_MIN = {1'b1, {(FP_WIDTH_DEF-1){1'b0}}};

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Half an output LSB, expressed at full-product scale.
  function automatic longint round_const(input int frac, input int rnd);
    return (rnd != 0) ? (longint'(1) << (frac - 1)) : longint'(0);
  endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Stream interface of the multi-lane fixed-point multiplier: operand beat in,
// product beat out, each with its own valid/ready pair.
interface fp_mult_pipe_if
  import fp_pkg::*;
#(
  parameter int FP_WIDTH = FP_WIDTH_DEF,
  parameter int LANES    = 3
);

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*FP_WIDTH-1:0] in_a;
  logic [LANES*FP_WIDTH-1:0] in_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*FP_WIDTH-1:0] out_p;
  logic [LANES-1:0]          out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, out_ovf
  );

endinterface

// File: rtl/fp_mult_lane.sv
// One lane of the fixed-point multiplier: operand register, product register(s),
// then round/shift/saturate into the output register, all gated by adv.
module fp_mult_lane
  import fp_pkg::*;
#(
  parameter int FP_WIDTH = FP_WIDTH_DEF,
  parameter int FP_FRAC  = FP_FRAC_DEF,
  parameter int STAGES   = 3,
  parameter int ROUND    = 1,
  parameter int SAT      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adv,
  input  logic signed [FP_WIDTH-1:0] a,
  input  logic signed [FP_WIDTH-1:0] b,
  output logic signed [FP_WIDTH-1:0] p,
  output logic                       ovf
);

  localparam int PW = 2 * FP_WIDTH;
  localparam logic signed [PW:0] RC = (PW+1)'(round_const(FP_FRAC, ROUND));
  localparam logic signed [FP_WIDTH-1:0] MAXV = {1'b0, {(FP_WIDTH-1){1'b1}}};
  localparam logic signed [FP_WIDTH-1:0] MINV = {1'b1, {(FP_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]       full;
  logic signed [PW:0]         rounded;
  logic signed [PW:0]         shifted;
  logic                       fits;
  logic signed [FP_WIDTH-1:0] res_p;
  logic                       res_ovf;

  generate
    if (STAGES == 1) begin : g_comb
      assign full = {{FP_WIDTH{a[FP_WIDTH-1]}}, a} * {{FP_WIDTH{b[FP_WIDTH-1]}}, b};
    end else begin : g_pipe
      logic signed [FP_WIDTH-1:0] a_q;
      logic signed [FP_WIDTH-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a;
          b_q <= b;
        end
      end

      if (STAGES == 2) begin : g_two
        assign full = {{FP_WIDTH{a_q[FP_WIDTH-1]}}, a_q} * {{FP_WIDTH{b_q[FP_WIDTH-1]}}, b_q};
      end else begin : g_prod
        logic signed [PW-1:0] prod_q [STAGES-2];

        // Deeper configurations only add product delay slots.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int i = 0; i < STAGES-2; i++) prod_q[i] <= '0;
          end else if (adv) begin
            prod_q[0] <= {{FP_WIDTH{a_q[FP_WIDTH-1]}}, a_q} * {{FP_WIDTH{b_q[FP_WIDTH-1]}}, b_q};
            for (int i = 1; i < STAGES-2; i++) prod_q[i] <= prod_q[i-1];
          end
        end

        assign full = prod_q[STAGES-3];
      end
    end
  endgenerate

  // One extra bit keeps the rounding add from overflowing; fits means every
  // bit above the output sign bit is a copy of it.
  always_comb begin
    rounded = $signed({full[PW-1], full}) + RC;
    shifted = rounded >>> FP_FRAC;
    fits    = (&shifted[PW:FP_WIDTH-1]) | ~(|shifted[PW:FP_WIDTH-1]);
    res_p   = shifted[FP_WIDTH-1:0];
    res_ovf = 1'b0;
    if ((SAT != 0) && !fits) begin
      res_p   = shifted[PW] ? MINV : MAXV;
      res_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p   <= '0;
      ovf <= 1'b0;
    end else if (adv) begin
      p   <= res_p;
      ovf <= res_ovf;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Multi-lane pipelined fixed-point multiplier with a global stall: every stage
// advances together whenever the output register is empty or being drained.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int FP_WIDTH = FP_WIDTH_DEF,
  parameter int FP_FRAC  = FP_FRAC_DEF,
  parameter int LANES    = 3,
  parameter int STAGES   = 3,
  parameter int ROUND    = 1,
  parameter int SAT      = 1
) (
  input  logic           clk,
  input  logic           rst,
  fp_mult_pipe_if.slave  bus
);

  logic              adv;
  logic [STAGES-1:0] vld;

  assign adv           = !vld[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld[STAGES-1];

  // Bubbles travel with the data; nothing collapses them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= bus.in_valid;
      for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      fp_mult_lane #(
        .FP_WIDTH (FP_WIDTH),
        .FP_FRAC  (FP_FRAC),
        .STAGES   (STAGES),
        .ROUND    (ROUND),
        .SAT      (SAT)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .adv (adv),
        .a   (bus.in_a[lane_lo(i, FP_WIDTH) +: FP_WIDTH]),
        .b   (bus.in_b[lane_lo(i, FP_WIDTH) +: FP_WIDTH]),
        .p   (bus.out_p[lane_lo(i, FP_WIDTH) +: FP_WIDTH]),
        .ovf (bus.out_ovf[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench: four multiplier configurations fed the same stimulus,
// each scored against a plain-arithmetic reference model.
module tb_fp_mult_pipe;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int W = 16;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [47:0] in_a = '0;
  logic [47:0] in_b = '0;
  logic        out_ready = 1'b1;
  logic        doDrain = 1'b0;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Q7.8 product straight from the arithmetic definition.
  function automatic logic [16:0] laneModel(input logic [15:0] a, input logic [15:0] b,
                                            input int rnd, input int sat);
    longint sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    s  = (sa * sb + ((rnd != 0) ? 128 : 0)) >>> 8;
    if ((s > 32767 || s < -32768) && sat != 0)
      return (s > 0) ? 17'h17FFF : 17'h18000;
    return {1'b0, s[15:0]};
  endfunction

  function automatic logic [50:0] beatModel(input logic [47:0] a, input logic [47:0] b,
                                            input int rnd, input int sat);
    logic [47:0] p;
    logic [2:0]  o;
    logic [16:0] r;
    for (int i = 0; i < L; i++) begin
      r = laneModel(a[i*16 +: 16], b[i*16 +: 16], rnd, sat);
      p[i*16 +: 16] = r[15:0];
      o[i] = r[16];
    end
    return {o, p};
  endfunction

  function automatic logic [15:0] randOp();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'($urandom_range(0, 511)) - 16'd256;
      default: return 16'($urandom);
    endcase
  endfunction

  generate
    for (genvar k = 0; k < 4; k++) begin : g_dut
      localparam int S  = (k == 0) ? 3 : (k == 1) ? 1 : (k == 2) ? 2 : 4;
      localparam int R  = (k == 0 || k == 2) ? 1 : 0;
      localparam int SA = (k == 0 || k == 3) ? 1 : 0;

      fp_mult_pipe_if #(.FP_WIDTH(W), .LANES(L)) bus ();
      assign bus.in_valid  = in_valid;
      assign bus.in_a      = in_a;
      assign bus.in_b      = in_b;
      assign bus.out_ready = out_ready;

      fp_mult_pipe #(
        .FP_WIDTH (W),
        .FP_FRAC  (8),
        .LANES    (L),
        .STAGES   (S),
        .ROUND    (R),
        .SAT      (SA)
      ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
      );

      logic [50:0] q [$];
      logic [47:0] lastP = '0;
      logic [2:0]  lastOvf = '0;
      logic        prevStall = 1'b0;
      logic [50:0] prevOut = '0;
      logic        drainDone = 1'b0;

      // Compare process: sampled mid-cycle, describing the coming rising edge.
      always @(negedge clk) begin
        if (rst) begin
          q.delete();
          prevStall <= 1'b0;
        end else begin
          if (prevStall && bus.out_valid)
            checkOutput($sformatf("hold_k%0d", k), 64'({bus.out_ovf, bus.out_p}), 64'(prevOut));
          if (bus.out_valid && !out_ready)
            checkOutput($sformatf("stall_in_ready_k%0d", k), 64'(bus.in_ready), 64'(0));
          if (bus.out_valid && out_ready) begin
            if (q.size() == 0)
              checkOutput($sformatf("spurious_beat_k%0d", k), 64'(1), 64'(0));
            else
              checkOutput($sformatf("score_k%0d", k), 64'({bus.out_ovf, bus.out_p}), 64'(q.pop_front()));
            lastP   <= bus.out_p;
            lastOvf <= bus.out_ovf;
          end
          if (in_valid && bus.in_ready)
            q.push_back(beatModel(in_a, in_b, R, SA));
          prevStall <= bus.out_valid && !out_ready;
          prevOut   <= {bus.out_ovf, bus.out_p};
          if (doDrain && !drainDone) begin
            checkOutput($sformatf("drain_k%0d", k), 64'(q.size()), 64'(0));
            drainDone <= 1'b1;
          end
        end
      end
    end
  endgenerate

  task automatic applyStimulus(input logic [47:0] a, input logic [47:0] b);
    int   n = 0;
    logic took = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!took && n < 100) begin
      @(negedge clk);
      took = g_dut[0].bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) checkOutput("accept_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  // Called right after an accepting edge N on an empty main pipe.
  task automatic checkLatency(input string name, input logic [47:0] expP);
    @(negedge clk);
    checkOutput({name, "_edge1"}, 64'(g_dut[0].bus.out_valid), 64'(0));
    @(negedge clk);
    checkOutput({name, "_edge2"}, 64'(g_dut[0].bus.out_valid), 64'(0));
    @(negedge clk);
    checkOutput({name, "_edge3"}, 64'(g_dut[0].bus.out_valid), 64'(1));
    checkOutput({name, "_p"}, 64'({g_dut[0].bus.out_ovf, g_dut[0].bus.out_p}), 64'({3'b000, expP}));
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d", nPass, nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(g_dut[0].bus.in_ready), 64'(1));
    checkOutput("rst_out_valid", 64'(g_dut[0].bus.out_valid), 64'(0));
    checkOutput("rst_out_p", 64'({g_dut[0].bus.out_ovf, g_dut[0].bus.out_p}), 64'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic: 1.5 * 2.0 on every lane, plus the latency of the main pipe.
    applyStimulus(48'h0180_0180_0180, 48'h0200_0200_0200);
    checkLatency("basic_latency", 48'h0300_0300_0300);
    repeat (4) @(negedge clk);
    checkOutput("basic_k0", 64'(g_dut[0].lastP), 64'(48'h0300_0300_0300));
    checkOutput("basic_k1", 64'(g_dut[1].lastP), 64'(48'h0300_0300_0300));
    checkOutput("basic_k3", 64'(g_dut[3].lastP), 64'(48'h0300_0300_0300));
    @(posedge clk);
    #1;

    // Rounding: lane0 +1*0.5 LSB, lane1 -1*0.5 LSB, lane2 exact.
    applyStimulus(48'h0180_FFFF_0001, 48'h0200_0080_0080);
    repeat (6) @(negedge clk);
    checkOutput("round_on_k0", 64'(g_dut[0].lastP), 64'(48'h0300_0000_0001));
    checkOutput("round_on_k2", 64'(g_dut[2].lastP), 64'(48'h0300_0000_0001));
    checkOutput("round_off_k1", 64'(g_dut[1].lastP), 64'(48'h0300_FFFF_0000));
    checkOutput("round_off_k3", 64'(g_dut[3].lastP), 64'(48'h0300_FFFF_0000));
    @(posedge clk);
    #1;

    // Saturation corners, including min*min.
    applyStimulus(48'h8000_8000_7F00, 48'h8000_0200_0200);
    repeat (6) @(negedge clk);
    checkOutput("sat_on_k0", 64'({g_dut[0].lastOvf, g_dut[0].lastP}), 64'({3'b111, 48'h7FFF_8000_7FFF}));
    checkOutput("sat_on_k3", 64'({g_dut[3].lastOvf, g_dut[3].lastP}), 64'({3'b111, 48'h7FFF_8000_7FFF}));
    checkOutput("sat_off_k1", 64'({g_dut[1].lastOvf, g_dut[1].lastP}), 64'({3'b000, 48'h0000_0000_FE00}));
    checkOutput("sat_off_k2", 64'({g_dut[2].lastOvf, g_dut[2].lastP}), 64'({3'b000, 48'h0000_0000_FE00}));
    @(posedge clk);
    #1;

    // Backpressure: 20 random beats with a 5-cycle downstream hold.
    fork
      begin
        for (int i = 0; i < 20; i++)
          applyStimulus({randOp(), randOp(), randOp()}, {randOp(), randOp(), randOp()});
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;

    // Reset with three beats in flight.
    applyStimulus(48'h0100_0100_0100, 48'h0100_0100_0100);
    applyStimulus(48'h0200_0200_0200, 48'h0100_0100_0100);
    applyStimulus(48'h0300_0300_0300, 48'h0100_0100_0100);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 64'(g_dut[0].bus.out_valid), 64'(0));
    checkOutput("midrst_out_p", 64'({g_dut[0].bus.out_ovf, g_dut[0].bus.out_p}), 64'(0));
    checkOutput("midrst_in_ready", 64'(g_dut[0].bus.in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("midrst_quiet", 64'(g_dut[0].bus.out_valid), 64'(0));
    @(posedge clk);
    #1;
    applyStimulus(48'h0100_0200_0300, 48'h0280_0280_0280);
    checkLatency("post_rst", 48'h0280_0500_0780);
    repeat (4) @(posedge clk);
    #1;

    // Soak: random valid/ready across all four pipeline depths.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_a = {randOp(), randOp(), randOp()};
      in_b = {randOp(), randOp(), randOp()};
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 doDrain = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
